// File: rtl/logs_sweep_ctrl.sv
// ============================================================================
// Module      : logs_sweep_ctrl
// Description : Sweep sequencer for the logistic-map iterator. Steps r across
//               COLS columns. For each column it resets the iterator, discards
//               SETTLE transient iterations, then forwards SAMPLES x values
//               with their column index over a valid/ready handshake.
//               Optional macro LOGS_SWEEP_LOOP_EN: repeat sweeps continuously
//               after the first start instead of returning to IDLE.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module logs_sweep_ctrl #(
  parameter int               FRAC    = 4,
  parameter int               COLS    = 64,
  parameter int               COL_W   = 6,
  parameter logic [FRAC+1:0]  R_START = 6'h2C,
  parameter int               R_STEP  = 1,
  parameter int               SETTLE  = 16,
  parameter int               SAMPLES = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [FRAC+1:0]   r_out,
  output logic              iter_rst,
  input  logic              next_ready,
  input  logic [FRAC-1:0]   x_in,
  output logic              pt_valid,
  input  logic              pt_ready,
  output logic [COL_W-1:0]  pt_col,
  output logic [FRAC-1:0]   pt_x,
  output logic              busy,
  output logic              done
);

  // Counters only need to reach LAST values, so size them for N-1.
  localparam int SET_W = (SETTLE  > 1) ? $clog2(SETTLE)  : 1;
  localparam int SMP_W = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;

  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [SMP_W-1:0] SAMPLE_LAST = SMP_W'(SAMPLES - 1);
  localparam logic [COL_W-1:0] COL_LAST    = COL_W'(COLS - 1);
  localparam logic [FRAC+2:0]  STEP_EXT    = (FRAC + 3)'(R_STEP);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RST    = 3'd1,
    S_SETTLE = 3'd2,
    S_SAMPLE = 3'd3,
    S_FIN    = 3'd4
  } state_t;

  state_t           state;
  logic [COL_W-1:0] col;
  logic [SET_W-1:0] settle_cnt;
  logic [SMP_W-1:0] sample_cnt;

  // r_out doubles as the r accumulator; one extra bit catches overflow so
  // the value clamps at all-ones instead of wrapping back to a small r.
  logic [FRAC+2:0] r_sum;
  logic [FRAC+1:0] r_inc;

  assign r_sum = {1'b0, r_out} + STEP_EXT;
  assign r_inc = r_sum[FRAC+2] ? {(FRAC + 2){1'b1}} : r_sum[FRAC+1:0];

  // Sweep state machine with all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      col        <= '0;
      r_out      <= R_START;
      iter_rst   <= 1'b1;
      settle_cnt <= '0;
      sample_cnt <= '0;
      pt_valid   <= 1'b0;
      pt_col     <= '0;
      pt_x       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          iter_rst <= 1'b1;
          if (start) begin
            state <= S_RST;
            busy  <= 1'b1;
          end
        end

        S_RST: begin
          // iter_rst is already high for this cycle; release it on exit.
          settle_cnt <= '0;
          sample_cnt <= '0;
          iter_rst   <= 1'b0;
          if (SETTLE == 0) begin
            state <= S_SAMPLE;
          end else begin
            state <= S_SETTLE;
          end
        end

        S_SETTLE: begin
          if (next_ready) begin
            if (settle_cnt == SETTLE_LAST) begin
              state <= S_SAMPLE;
            end else begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end
        end

        S_SAMPLE: begin
          if (pt_valid) begin
            // While a point is pending any next_ready is dropped, including
            // one that coincides with the transfer.
            if (pt_ready) begin
              pt_valid <= 1'b0;
              if (sample_cnt == SAMPLE_LAST) begin
                sample_cnt <= '0;
                iter_rst   <= 1'b1;
                if (col == COL_LAST) begin
                  state <= S_FIN;
                  done  <= 1'b1;
`ifdef LOGS_SWEEP_LOOP_EN
                  busy  <= 1'b1;
`else
                  busy  <= 1'b0;
`endif
                end else begin
                  col   <= col + 1'b1;
                  r_out <= r_inc;
                  state <= S_RST;
                end
              end else begin
                sample_cnt <= sample_cnt + 1'b1;
              end
            end
          end else if (next_ready) begin
            pt_valid <= 1'b1;
            pt_x     <= x_in;
            pt_col   <= col;
          end
        end

        S_FIN: begin
          col   <= '0;
          r_out <= R_START;
`ifdef LOGS_SWEEP_LOOP_EN
          state <= S_RST;
`else
          state <= S_IDLE;
`endif
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_logs_sweep_ctrl.sv
// ============================================================================
// Module      : tb_logs_sweep_ctrl
// Description : Self-checking bench for logs_sweep_ctrl with a behavioural
//               reference model and a simple iterator model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_logs_sweep_ctrl;

  localparam int        FRAC    = 4;
  localparam int        COLS    = 5;
  localparam int        COL_W   = 3;
  localparam logic [5:0] R_START = 6'h3A;
  localparam int        R_STEP  = 2;
  localparam int        SETTLE  = 2;
  localparam int        SAMPLES = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [FRAC+1:0]  r_out;
  logic             iter_rst;
  logic             next_ready;
  logic [FRAC-1:0]  x_in;
  logic             pt_valid;
  logic             pt_ready;
  logic [COL_W-1:0] pt_col;
  logic [FRAC-1:0]  pt_x;
  logic             busy;
  logic             done;

  logs_sweep_ctrl #(
    .FRAC(FRAC), .COLS(COLS), .COL_W(COL_W), .R_START(R_START),
    .R_STEP(R_STEP), .SETTLE(SETTLE), .SAMPLES(SAMPLES)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .r_out(r_out),
    .iter_rst(iter_rst), .next_ready(next_ready), .x_in(x_in),
    .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_col(pt_col),
    .pt_x(pt_x), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 idle, 1 column reset, 2 running, 3 finish.
  int       m_phase, m_col, m_seen, m_taken, m_pcol;
  bit       m_hold, m_busy, m_done;
  logic [3:0] m_x;

  // Stimulus modes: ready 0=low 1=high 2=random; period 0=random pulses.
  int ready_mode, nr_period, x_mode;
  int it_cyc, it_cnt;

  int log_col[$];
  int log_x[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic reset_model();
    m_phase = 0; m_col = 0; m_seen = 0; m_taken = 0; m_pcol = 0;
    m_hold = 0; m_busy = 0; m_done = 0; m_x = '0;
  endtask

  function automatic int exp_r();
    int v;
    if (m_phase == 0) return int'(R_START);
    v = int'(R_START) + m_col * R_STEP;
    return (v > 63) ? 63 : v;
  endfunction

  task automatic model_step();
    bit nd;
    nd = 0;
    case (m_phase)
      0: if (start) begin m_phase = 1; m_busy = 1; end
      1: begin m_seen = 0; m_taken = 0; m_phase = 2; end
      2: begin
        if (m_seen < SETTLE) begin
          if (next_ready) m_seen++;
        end else if (m_hold) begin
          if (pt_ready) begin
            m_hold = 0;
            m_taken++;
            if (m_taken == SAMPLES) begin
              if (m_col == COLS - 1) begin
                m_phase = 3;
                nd = 1;
`ifndef LOGS_SWEEP_LOOP_EN
                m_busy = 0;
`endif
              end else begin
                m_col++;
                m_phase = 1;
              end
            end
          end
        end else if (next_ready) begin
          m_hold = 1; m_x = x_in; m_pcol = m_col;
        end
      end
      default: begin
        m_col = 0;
`ifdef LOGS_SWEEP_LOOP_EN
        m_phase = 1;
`else
        m_phase = 0;
`endif
      end
    endcase
    m_done = nd;
  endtask

  task automatic check_all();
    chk("r_out",    32'(r_out),    32'(exp_r()));
    chk("iter_rst", 32'(iter_rst), 32'(m_phase != 2));
    chk("pt_valid", 32'(pt_valid), 32'(m_hold));
    chk("pt_col",   32'(pt_col),   32'(m_pcol));
    chk("pt_x",     32'(pt_x),     32'(m_x));
    chk("busy",     32'(busy),     32'(m_busy));
    chk("done",     32'(done),     32'(m_done));
  endtask

  task automatic drive();
    bit fire;
    start = 1'b0;
    if (iter_rst) begin
      it_cyc = 0; it_cnt = 0; next_ready = 1'b0;
    end else begin
      it_cyc++;
      if (nr_period == 0) fire = ($urandom_range(0, 2) == 0);
      else                fire = ((it_cyc % nr_period) == 0);
      next_ready = fire;
      if (fire) begin
        it_cnt++;
        x_in = (x_mode != 0) ? 4'($urandom) : 4'(it_cnt);
      end
    end
    case (ready_mode)
      0:       pt_ready = 1'b0;
      1:       pt_ready = 1'b1;
      default: pt_ready = 1'($urandom_range(0, 1));
    endcase
    if (pt_valid && pt_ready) begin
      log_col.push_back(int'(pt_col));
      log_x.push_back(int'(pt_x));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
    drive();
  endtask

  task automatic run_until_done(input int budget);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!m_done && n < budget);
    checks++;
    assert (m_done) else begin
      errors++;
      $error("FAIL sweep_timeout observed=%0d cycles expected=done", n);
    end
    step();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_r_out"},    32'(r_out),    32'(R_START));
    chk({tag, "_iter_rst"}, 32'(iter_rst), 32'd1);
    chk({tag, "_pt_valid"}, 32'(pt_valid), 32'd0);
    chk({tag, "_pt_col"},   32'(pt_col),   32'd0);
    chk({tag, "_pt_x"},     32'(pt_x),     32'd0);
    chk({tag, "_busy"},     32'(busy),     32'd0);
    chk({tag, "_done"},     32'(done),     32'd0);
  endtask

  initial begin
    int n;
    reset = 1'b0; start = 1'b0; next_ready = 1'b0; x_in = '0; pt_ready = 1'b1;
    ready_mode = 1; nr_period = 20; x_mode = 0; it_cyc = 0; it_cnt = 0;
    reset_model();
    #1 reset = 1'b1;
    #1 check_reset_values("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Sweep with slow iterator and counting x: fixed point sequence expected.
    log_col.delete(); log_x.delete();
    start = 1'b1;
    run_until_done(4000);
    chk("sweep_points", 32'(log_col.size()), 32'(COLS * SAMPLES));
    for (int i = 0; i < log_col.size() && i < COLS * SAMPLES; i++) begin
      chk("sweep_col", 32'(log_col[i]), 32'(i / SAMPLES));
      chk("sweep_x",   32'(log_x[i]),   32'(SETTLE + 1 + (i % SAMPLES)));
    end

    // start pulsed mid-sweep must be ignored.
    nr_period = 3;
    start = 1'b1;
    for (int i = 0; i < 30; i++) step();
    start = 1'b1;
    step();
    run_until_done(2000);

    // Back-pressure: hold pt_ready low for 50 cycles with a pending point.
    ready_mode = 1; nr_period = 2;
    start = 1'b1;
    n = 0;
    do begin step(); n++; end while (!(m_hold && m_phase == 2) && n < 500);
    ready_mode = 0;
    for (int i = 0; i < 50; i++) step();
    chk("hold_valid", 32'(pt_valid), 32'd1);
    ready_mode = 1;
    run_until_done(2000);

    // Randomized sweeps.
    ready_mode = 2; nr_period = 0; x_mode = 1;
    for (int s = 0; s < 3; s++) begin
      start = 1'b1;
      run_until_done(3000);
    end

    // Asynchronous reset during column 2 with a point pending.
    start = 1'b1;
    n = 0;
    do begin step(); n++; end while (!(m_col == 2 && m_hold) && n < 3000);
    #2 reset = 1'b1;
    #1 check_reset_values("midreset");
    reset_model();
    @(negedge clk);
    check_all();
    reset = 1'b0;
    drive();

    // Restart after reset begins again at column 0.
    ready_mode = 1;
    log_col.delete(); log_x.delete();
    start = 1'b1;
    run_until_done(3000);
    chk("restart_points", 32'(log_col.size()), 32'(COLS * SAMPLES));
    if (log_col.size() > 0) chk("restart_col0", 32'(log_col[0]), 32'd0);

`ifdef LOGS_SWEEP_LOOP_EN
    // Continuous mode: the next sweep runs without another start.
    log_col.delete(); log_x.delete();
    run_until_done(3000);
    chk("loop_points", 32'(log_col.size()), 32'(COLS * SAMPLES));
    if (log_col.size() > 0) chk("loop_col0", 32'(log_col[0]), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/logs_sweep_ctrl.md
Name: logs_sweep_ctrl

Overview:
Sequencer for the logistic-map iterator. Sweeps the map parameter r across a fixed number of display columns. For each column it resets the iterator, discards SETTLE transient iterations, then forwards SAMPLES x values with their column index to a downstream plot buffer over a valid/ready handshake. Sits between the top-level run/start control and the iterator, and owns the iterator's r input and reset.

Parameters:
FRAC, 4, fraction bits of x; r is 2.FRAC fixed-point
COLS, 64, number of r columns in one sweep (>= 1)
COL_W, 6, width of column index (>= clog2(COLS))
R_START, 6'h2C (2.75), r for column 0, 2.FRAC
R_STEP, 1, r increment per column, 2.FRAC LSBs
SETTLE, 16, iterations discarded per column (>= 0)
SAMPLES, 8, iterations forwarded per column (>= 1)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle request to begin a sweep; ignored unless idle
r_out  out  FRAC+2  r value driven to the iterator
iter_rst  out  1  reset to the iterator, active high
next_ready  in  1  iterator pulse: new x valid this cycle
x_in  in  FRAC  iterator x output
pt_valid  out  1  sample point available
pt_ready  in  1  downstream accepts point
pt_col  out  COL_W  column index of point
pt_x  out  FRAC  x value of point
busy  out  1  high from sweep start until return to IDLE
done  out  1  one-cycle pulse when the last point of the sweep is accepted

Behaviour:
- Reset values: r_out=R_START, iter_rst=1, pt_valid=0, pt_col=0, pt_x=0, busy=0, done=0. Internal state=IDLE, col=0, all counters 0.
- IDLE: iter_rst held 1 so the iterator stays quiescent. On start=1, go to RST and set busy=1.
- RST (1 cycle): iter_rst=1; r_out=R_START+col*R_STEP (held as an accumulator, += R_STEP per column). Reset the settle and sample counters. Next state is SETTLE.
- SETTLE: iter_rst=0. Count next_ready pulses. Once SETTLE pulses have been seen, go to SAMPLE. With SETTLE=0, go directly from RST to SAMPLE.
- SAMPLE: on next_ready while pt_valid=0, latch pt_x<=x_in and pt_col<=col; pt_valid rises the following cycle.
  - A next_ready arriving while pt_valid=1 is dropped: not counted, pt_x unchanged.
  - A transfer occurs when pt_valid & pt_ready. pt_valid falls the next cycle and the sample count increments.
  - pt_valid, pt_x and pt_col stay stable until the transfer.
  - After the SAMPLES-th transfer: if col==COLS-1, go to FIN; otherwise col+=1 and go to RST.
- FIN (1 cycle): done=1, busy=0, col=0, r accumulator reloaded to R_START. Next state is IDLE.
- r arithmetic: computed in FRAC+3 bits and saturated to all-ones FRAC+2 bits. There is no wrap-around.
- Simultaneous events:
  - A transfer and next_ready in the same cycle: the transfer completes, and that next_ready is dropped.
  - start while busy is ignored.
- Latency: the first point of a column needs >= (SETTLE+1)*(iterator cycle length) clocks after RST. The controller adds 1 cycle (RST) per column plus 1 cycle from next_ready to pt_valid.
- Reset mid-sweep: returns immediately to reset values. No partial point is emitted after reset deasserts.

Optional Feature:
LOGS_SWEEP_LOOP_EN.
- Defined: FIN transitions to RST instead of IDLE. Sweeps repeat continuously, busy stays 1, done still pulses at each sweep end, and start is only needed for the first sweep.
- Undefined: a single sweep per start, as above.

Test Plan:
- Config FRAC=4, COLS=4, SETTLE=2, SAMPLES=2, R_START=6'h30, R_STEP=2, pt_ready=1. Pulse start -> r_out 0x30,0x32,0x34,0x36 in turn, iter_rst 1-cycle pulse per column, 8 points with pt_col 0,0,1,1,2,2,3,3, then done pulse and busy=0.
- Same config with a model iterator giving next_ready every 20 cycles and x=1..n -> first point of each column carries the third x after iter_rst (first two discarded).
- Hold pt_ready=0 for 50 cycles during SAMPLE -> pt_valid stays high with pt_x/pt_col stable, intervening next_ready pulses dropped, sample count unchanged.
- R_START=6'h3E, R_STEP=1, COLS=4 -> r_out 0x3E,0x3F,0x3F,0x3F (saturation).
- Assert reset during column 2 SAMPLE with pt_valid=1 -> same cycle pt_valid=0, busy=0, iter_rst=1, r_out=R_START; a new start restarts at col 0.
- start pulsed while busy -> no effect. With LOGS_SWEEP_LOOP_EN, after done the sweep restarts at col 0 without start.
